// File: rtl/multdiv_sched.sv
// multdiv_sched: shares one multiplier/divider between the two issue lanes.
// It serves the DX-stage mult/div requests in program order (lane 0 first).
// It pulses a start to the unit with held operands and waits for ready.
// It returns each result with its rd and stalls DX/XM until the bundle is done.
// Ports:
//   clock, reset           : clock and asynchronous active-high reset
//   flush                  : kill the current DX bundle
//   req{0,1}_*             : per-lane request (valid, isDiv, a, b, rd)
//   md_ready/exception/result : unit status and result
//   md_ctrlMult/Div, md_opA/B : unit start pulses and held operands
//   stall, busy            : pipeline hold, scheduler not idle
//   done_*                 : completed-op result (done_valid is a pulse)
module multdiv_sched #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic              req0_isDiv,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [REG_W-1:0]  req0_rd,
    input  logic              req1_valid,
    input  logic              req1_isDiv,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [REG_W-1:0]  req1_rd,
    input  logic              md_ready,
    input  logic              md_exception,
    input  logic [DATA_W-1:0] md_result,
    output logic              md_ctrlMult,
    output logic              md_ctrlDiv,
    output logic [DATA_W-1:0] md_opA,
    output logic [DATA_W-1:0] md_opB,
    output logic              stall,
    output logic              busy,
    output logic              done_valid,
    output logic              done_lane,
    output logic [REG_W-1:0]  done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              done_exc
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]        r_served;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_opA;
    logic [DATA_W-1:0] r_opB;
    logic [REG_W-1:0]  r_rd;
    logic              r_isDiv;
    logic              r_lane;
    logic              r_done_lane;
    logic [REG_W-1:0]  r_done_rd;
    logic [DATA_W-1:0] r_done_data;
    logic              r_done_exc;

    logic w_pend0;
    logic w_pend1;
    logic w_take;
    logic w_sel1;
    logic w_fin_rdy;
    logic w_fin_to;
    logic w_fin;
    logic w_stall;

    assign w_pend0 = req0_valid & ~r_served[0];
    assign w_pend1 = req1_valid & ~r_served[1];
    assign w_stall = (w_pend0 | w_pend1) & ~reset & ~flush;

    // Lane 0 always wins when both lanes are pending: program order.
    assign w_take = (r_state == S_IDLE) & (w_pend0 | w_pend1) & ~flush;
    assign w_sel1 = ~w_pend0;

    // Ready outranks the timeout when both occur in the last WAIT cycle.
    assign w_fin_rdy = (r_state == S_WAIT) & md_ready & ~flush;
    assign w_fin_to  = (r_state == S_WAIT) & ~md_ready
                     & (r_cnt == CNT_MAX) & ~flush;
    assign w_fin     = w_fin_rdy | w_fin_to;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_take) w_next = S_START;
                S_START: w_next = S_WAIT;
                S_WAIT:  if (w_fin) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        md_ctrlMult = 1'b0;
        md_ctrlDiv  = 1'b0;
        done_valid  = 1'b0;
        busy        = (r_state != S_IDLE);
        unique case (r_state)
            S_START: begin
                md_ctrlMult = ~r_isDiv & ~flush;
                md_ctrlDiv  = r_isDiv & ~flush;
            end
            S_DONE:  done_valid = ~flush;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_served    <= 2'b00;
            r_cnt       <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_rd        <= '0;
            r_isDiv     <= 1'b0;
            r_lane      <= 1'b0;
            r_done_lane <= 1'b0;
            r_done_rd   <= '0;
            r_done_data <= '0;
            r_done_exc  <= 1'b0;
        end else begin
            if (w_take) begin
                r_opA   <= w_sel1 ? req1_a : req0_a;
                r_opB   <= w_sel1 ? req1_b : req0_b;
                r_rd    <= w_sel1 ? req1_rd : req0_rd;
                r_isDiv <= w_sel1 ? req1_isDiv : req0_isDiv;
                r_lane  <= w_sel1;
            end

            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && !w_fin && !flush) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_fin) begin
                r_done_lane <= r_lane;
                r_done_rd   <= r_rd;
                r_done_data <= w_fin_rdy ? md_result : '0;
                r_done_exc  <= w_fin_rdy ? md_exception : 1'b1;
            end

            // A bundle leaves DX on any edge without stall.
            if (flush) begin
                r_served <= 2'b00;
            end else if (w_fin) begin
                r_served[r_lane] <= 1'b1;
            end else if (!w_stall) begin
                r_served <= 2'b00;
            end
        end
    end

    assign md_opA    = r_opA;
    assign md_opB    = r_opB;
    assign stall     = w_stall;
    assign done_lane = r_done_lane;
    assign done_rd   = r_done_rd;
    assign done_data = r_done_data;
    assign done_exc  = r_done_exc;

endmodule

// File: tb/tb_multdiv_sched.sv
// tb_multdiv_sched: directed self-checking bench for multdiv_sched.
// Inputs change 2ns after each rising edge; outputs are checked 1ns later.
module tb_multdiv_sched;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        req0_valid;
    logic        req0_isDiv;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req0_rd;
    logic        req1_valid;
    logic        req1_isDiv;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [4:0]  req1_rd;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        md_ctrlMult;
    logic        md_ctrlDiv;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic        stall;
    logic        busy;
    logic        done_valid;
    logic        done_lane;
    logic [4:0]  done_rd;
    logic [31:0] done_data;
    logic        done_exc;

    int total = 0;
    int bad   = 0;

    multdiv_sched #(
        .DATA_W(32),
        .REG_W(5),
        .TIMEOUT(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .req0_valid(req0_valid),
        .req0_isDiv(req0_isDiv),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req0_rd(req0_rd),
        .req1_valid(req1_valid),
        .req1_isDiv(req1_isDiv),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .req1_rd(req1_rd),
        .md_ready(md_ready),
        .md_exception(md_exception),
        .md_result(md_result),
        .md_ctrlMult(md_ctrlMult),
        .md_ctrlDiv(md_ctrlDiv),
        .md_opA(md_opA),
        .md_opB(md_opB),
        .stall(stall),
        .busy(busy),
        .done_valid(done_valid),
        .done_lane(done_lane),
        .done_rd(done_rd),
        .done_data(done_data),
        .done_exc(done_exc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic quiet();
        flush        = 1'b0;
        req0_valid   = 1'b0;
        req0_isDiv   = 1'b0;
        req0_a       = '0;
        req0_b       = '0;
        req0_rd      = '0;
        req1_valid   = 1'b0;
        req1_isDiv   = 1'b0;
        req1_a       = '0;
        req1_b       = '0;
        req1_rd      = '0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = '0;
    endtask

    task automatic lane0(input logic dv, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        req0_valid = 1'b1;
        req0_isDiv = dv;
        req0_a     = a;
        req0_b     = b;
        req0_rd    = rd;
    endtask

    task automatic lane1(input logic dv, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        req1_valid = 1'b1;
        req1_isDiv = dv;
        req1_a     = a;
        req1_b     = b;
        req1_rd    = rd;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".mult"}, md_ctrlMult, 0);
        chk({tag, ".div"}, md_ctrlDiv, 0);
        chk({tag, ".opA"}, md_opA, 0);
        chk({tag, ".opB"}, md_opB, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".stall"}, stall, 0);
        chk({tag, ".dv"}, done_valid, 0);
        chk({tag, ".dlane"}, done_lane, 0);
        chk({tag, ".drd"}, done_rd, 0);
        chk({tag, ".ddata"}, done_data, 0);
        chk({tag, ".dexc"}, done_exc, 0);
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        #12;
        chk_rst("rst");
        #5;
        reset = 1'b0;

        // Lane 0 mult 7x6 rd 5, ready 3 cycles after start
        step();
        lane0(1'b0, 32'd7, 32'd6, 5'd5);
        #1;
        chk("t1c0.stall", stall, 1);
        chk("t1c0.busy", busy, 0);
        chk("t1c0.mult", md_ctrlMult, 0);
        step(); #1;
        chk("t1c1.mult", md_ctrlMult, 1);
        chk("t1c1.div", md_ctrlDiv, 0);
        chk("t1c1.opA", md_opA, 7);
        chk("t1c1.opB", md_opB, 6);
        chk("t1c1.stall", stall, 1);
        step(); #1;
        chk("t1c2.mult", md_ctrlMult, 0);
        chk("t1c2.stall", stall, 1);
        step(); #1;
        chk("t1c3.stall", stall, 1);
        step();
        md_ready  = 1'b1;
        md_result = 32'd42;
        #1;
        chk("t1c4.dv", done_valid, 0);
        chk("t1c4.stall", stall, 1);
        step();
        md_ready = 1'b0;
        #1;
        chk("t1c5.dv", done_valid, 1);
        chk("t1c5.data", done_data, 42);
        chk("t1c5.rd", done_rd, 5);
        chk("t1c5.lane", done_lane, 0);
        chk("t1c5.exc", done_exc, 0);
        chk("t1c5.stall", stall, 0);
        step();
        quiet();
        #1;
        chk("t1c6.dv", done_valid, 0);
        chk("t1c6.busy", busy, 0);
        chk("t1c6.hold", done_data, 42);

        // Dual: lane 0 div 100/7 rd 3, lane 1 mult 9x9 rd 4
        step();
        lane0(1'b1, 32'd100, 32'd7, 5'd3);
        lane1(1'b0, 32'd9, 32'd9, 5'd4);
        #1;
        chk("t2c0.stall", stall, 1);
        step();
        md_ready  = 1'b1;
        md_result = 32'd99;
        #1;
        chk("t2c1.div", md_ctrlDiv, 1);
        chk("t2c1.mult", md_ctrlMult, 0);
        chk("t2c1.opA", md_opA, 100);
        chk("t2c1.opB", md_opB, 7);
        step();
        md_result = 32'd14;
        #1;
        chk("t2c2.dv", done_valid, 0);
        chk("t2c2.div", md_ctrlDiv, 0);
        step();
        md_ready = 1'b0;
        #1;
        chk("t2c3.dv", done_valid, 1);
        chk("t2c3.lane", done_lane, 0);
        chk("t2c3.data", done_data, 14);
        chk("t2c3.rd", done_rd, 3);
        chk("t2c3.stall", stall, 1);
        step(); #1;
        chk("t2c4.busy", busy, 0);
        chk("t2c4.stall", stall, 1);
        chk("t2c4.dv", done_valid, 0);
        step(); #1;
        chk("t2c5.mult", md_ctrlMult, 1);
        chk("t2c5.div", md_ctrlDiv, 0);
        chk("t2c5.opA", md_opA, 9);
        step();
        md_ready  = 1'b1;
        md_result = 32'd81;
        #1;
        chk("t2c6.stall", stall, 1);
        step();
        md_ready = 1'b0;
        #1;
        chk("t2c7.dv", done_valid, 1);
        chk("t2c7.lane", done_lane, 1);
        chk("t2c7.data", done_data, 81);
        chk("t2c7.rd", done_rd, 4);
        chk("t2c7.stall", stall, 0);
        step();
        quiet();

        // Lane 1 only: 3 x -2, then next bundle right after release
        step();
        lane1(1'b0, 32'd3, 32'hFFFF_FFFE, 5'd12);
        #1;
        chk("t3c0.stall", stall, 1);
        step(); #1;
        chk("t3c1.mult", md_ctrlMult, 1);
        chk("t3c1.opB", md_opB, 32'hFFFF_FFFE);
        step();
        md_ready  = 1'b1;
        md_result = 32'hFFFF_FFFA;
        #1;
        step();
        md_ready = 1'b0;
        #1;
        chk("t3c3.dv", done_valid, 1);
        chk("t3c3.lane", done_lane, 1);
        chk("t3c3.data", done_data, 32'hFFFF_FFFA);
        chk("t3c3.rd", done_rd, 12);
        chk("t3c3.stall", stall, 0);
        step();
        quiet();
        lane0(1'b0, 32'd2, 32'd2, 5'd1);
        #1;
        chk("t3c4.stall", stall, 1);
        chk("t3c4.busy", busy, 0);
        step(); #1;
        chk("t3c5.mult", md_ctrlMult, 1);
        chk("t3c5.opA", md_opA, 2);
        step();
        md_ready  = 1'b1;
        md_result = 32'd4;
        #1;
        step();
        md_ready = 1'b0;
        #1;
        chk("t3c7.dv", done_valid, 1);
        chk("t3c7.data", done_data, 4);
        chk("t3c7.lane", done_lane, 0);
        step();
        quiet();

        // Flush in WAIT, late ready ignored, fresh start afterwards
        step();
        lane0(1'b0, 32'd5, 32'd5, 5'd2);
        step(); #1;
        chk("t4c1.mult", md_ctrlMult, 1);
        step();
        flush = 1'b1;
        #1;
        chk("t4c2.stall", stall, 0);
        chk("t4c2.dv", done_valid, 0);
        step();
        quiet();
        md_ready  = 1'b1;
        md_result = 32'd25;
        #1;
        chk("t4c3.busy", busy, 0);
        chk("t4c3.stall", stall, 0);
        chk("t4c3.dv", done_valid, 0);
        step();
        md_ready = 1'b0;
        lane0(1'b0, 32'd6, 32'd7, 5'd6);
        #1;
        chk("t4c4.dv", done_valid, 0);
        chk("t4c4.busy", busy, 0);
        chk("t4c4.hold", done_data, 4);
        step(); #1;
        chk("t4c5.mult", md_ctrlMult, 1);
        chk("t4c5.opA", md_opA, 6);
        step();
        md_ready  = 1'b1;
        md_result = 32'd42;
        #1;
        step();
        md_ready = 1'b0;
        #1;
        chk("t4c7.dv", done_valid, 1);
        chk("t4c7.rd", done_rd, 6);
        chk("t4c7.data", done_data, 42);
        step();
        quiet();

        // Timeout: ready never comes
        step();
        lane0(1'b0, 32'd8, 32'd8, 5'd7);
        md_result = 32'h1234;
        step(); #1;
        chk("t5c1.mult", md_ctrlMult, 1);
        for (int i = 0; i < 64; i++) begin
            step(); #1;
            chk("t5wait.dv", done_valid, 0);
            chk("t5wait.busy", busy, 1);
        end
        step(); #1;
        chk("t5to.dv", done_valid, 1);
        chk("t5to.exc", done_exc, 1);
        chk("t5to.data", done_data, 0);
        chk("t5to.rd", done_rd, 7);
        chk("t5to.stall", stall, 0);
        step();
        quiet();

        // Divide by zero reported by the unit
        step();
        lane0(1'b1, 32'd9, 32'd0, 5'd8);
        step(); #1;
        chk("t6c1.div", md_ctrlDiv, 1);
        step();
        md_ready     = 1'b1;
        md_exception = 1'b1;
        md_result    = 32'hFFFF_FFFF;
        #1;
        step();
        md_ready     = 1'b0;
        md_exception = 1'b0;
        #1;
        chk("t6c3.dv", done_valid, 1);
        chk("t6c3.exc", done_exc, 1);
        chk("t6c3.data", done_data, 32'hFFFF_FFFF);
        chk("t6c3.rd", done_rd, 8);
        step();
        quiet();

        // Reset pulsed mid-WAIT
        step();
        lane0(1'b0, 32'd11, 32'd13, 5'd9);
        step();
        step(); #1;
        chk("t7c2.busy", busy, 1);
        reset = 1'b1;
        #1;
        chk_rst("t7rst");
        quiet();
        step(); #1;
        chk("t7held.busy", busy, 0);
        chk("t7held.dv", done_valid, 0);
        reset = 1'b0;
        step();
        lane0(1'b0, 32'd3, 32'd3, 5'd10);
        #1;
        chk("t7c0.stall", stall, 1);
        step(); #1;
        chk("t7c1.mult", md_ctrlMult, 1);
        chk("t7c1.opA", md_opA, 3);
        step();
        md_ready  = 1'b1;
        md_result = 32'd9;
        #1;
        step();
        md_ready = 1'b0;
        #1;
        chk("t7c3.dv", done_valid, 1);
        chk("t7c3.data", done_data, 9);
        chk("t7c3.rd", done_rd, 10);
        chk("t7c3.exc", done_exc, 0);
        step();
        quiet();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_sched.md
# multdiv_sched

Sequencer and arbiter that shares the single multiplier/divider unit between the two issue lanes of the 2-wide pipeline. It watches both lanes' DX-stage mult/div requests and serves them in program order, lane 0 first. It issues one-cycle start pulses with held operands to the unit and waits for its ready flag. It returns each result with its destination register, and drives the DX/XM stall until every mult/div in the bundle has completed.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, destination register index width
- TIMEOUT, 64, max WAIT cycles before abort (>= 2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  kill current DX bundle (branch/jump redirect)
- req0_valid  in  1  lane 0 DX op is mult/div
- req0_isDiv  in  1  lane 0 op: 1 = div, 0 = mult
- req0_a, req0_b  in  DATA_W  lane 0 operands
- req0_rd  in  REG_W  lane 0 destination
- req1_valid, req1_isDiv, req1_a, req1_b, req1_rd  in  1/1/DATA_W/DATA_W/REG_W  lane 1 equivalents
- md_ready  in  1  unit result ready (data_resultRDY)
- md_exception  in  1  unit exception (e.g. divide by zero)
- md_result  in  DATA_W  unit result
- md_ctrlMult  out  1  one-cycle mult start pulse
- md_ctrlDiv  out  1  one-cycle div start pulse
- md_opA, md_opB  out  DATA_W  registered operands, stable from START until next START
- stall  out  1  hold DX/XM (pipeline drives DXWrite/XMWrite low)
- busy  out  1  state != IDLE
- done_valid  out  1  one-cycle result pulse
- done_lane  out  1  lane of completed op
- done_rd  out  REG_W  destination of completed op
- done_data  out  DATA_W  result
- done_exc  out  1  unit exception or timeout

## Operation
- Registered served[1:0] marks lanes of the current bundle already completed.
- pending_i = req_i_valid & ~served[i].
- stall = (pending0 | pending1) & ~reset & ~flush. Combinational so the pipeline holds in the same cycle a request appears.
- Any edge with stall == 0 clears served to 00; the bundle leaves DX at that edge.
- The pipeline holds req* stable while stall = 1.
- State machine:
  - IDLE:
    - If pending0, select lane 0; else if pending1, select lane 1.
    - On selection, latch operands, rd, isDiv, lane; go START.
    - Otherwise stay.
  - START:
    - md_ctrlMult or md_ctrlDiv is 1 for this cycle only, per latched isDiv.
    - Clear the timeout counter; go WAIT.
  - WAIT:
    - md_ready is sampled only here; a ready seen in START is ignored.
    - On md_ready: register md_result, md_exception, rd, and lane into done_*; set served[lane]; go DONE.
    - If the counter reaches TIMEOUT - 1 without ready: done_data = 0, done_exc = 1; set served[lane]; go DONE.
    - Otherwise counter += 1 (width clog2(TIMEOUT), no wrap reached).
  - DONE:
    - done_valid = 1 for this cycle; go IDLE.
    - stall is recomputed with the updated served, so a remaining lane-1 op keeps stall high.
- flush (any state, priority over everything except reset):
  - Next state IDLE; served <= 00; no done_valid is issued for an aborted op.
  - A late md_ready after flush is ignored.
  - The next START pulse restarts the unit.
- Simultaneous flush and md_ready in WAIT: flush wins, result dropped.
- done_* registers hold their last value outside DONE; only done_valid is a pulse.

## Timing
- Reset state of all outputs:
  - IDLE, served = 00, counter = 0.
  - md_ctrlMult = md_ctrlDiv = 0, md_opA = md_opB = 0.
  - busy = 0, stall = 0.
  - done_valid = 0, done_lane = 0, done_rd = 0, done_data = 0, done_exc = 0.
- Single op, request first seen in cycle 0, md_ready in cycle k (k >= 2):
  - START pulse in cycle 1.
  - done_valid in cycle k+1; stall = 1 in cycles 0..k, 0 in k+1.
  - The bundle advances at the end of cycle k+1.
- Dual op adds a full second IDLE→START→WAIT→DONE sequence. stall stays high through the first DONE and falls in the second DONE.
- Back-to-back bundles: the next bundle's requests may appear the cycle after release. IDLE accepts them with no bubble.
- Reset asserted mid-operation returns immediately (asynchronously) to reset values. No done_valid is issued.

## Test plan
- Lane 0 mult 7×6, rd=5, md_ready 3 cycles after start:
  - md_ctrlMult pulse in cycle 1; done_valid in cycle 5 with done_data=42, done_rd=5, done_lane=0.
  - stall high in cycles 0–4, low in cycle 5.
- Both lanes, lane 0 div 100/7 rd=3, lane 1 mult 9×9 rd=4:
  - md_ctrlDiv pulse first, then md_ctrlMult.
  - Done pulses in order (lane 0, 14, rd 3) then (lane 1, 81, rd 4).
  - stall drops only in the second DONE.
- Lane 1 only, mult 3×(-2):
  - Lane 1 selected immediately; done_data = 0xFFFFFFFA.
  - served clears on release and the next bundle is accepted the following cycle.
- flush asserted in WAIT, then md_ready the next cycle:
  - No done_valid; state IDLE; stall 0.
  - A following lane 0 request produces a fresh start pulse.
- md_ready held 0, TIMEOUT=64:
  - done_valid 64 cycles after entering WAIT, with done_exc=1 and done_data=0.
  - Div by 0 with md_exception=1 gives done_exc=1.
- reset pulsed mid-WAIT:
  - All outputs return to reset values in the same cycle; no done_valid.
  - A request after reset is served normally.
